// File: rtl/stream_cipher_pkg.sv
// Shared types and default widths for the stream cipher datapath.
package cipher_pkg;

    localparam int DEF_DATA_W    = 8;
    localparam int DEF_KEY_DEPTH = 8;
    localparam int DEF_LEN_W     = 8;

    typedef enum logic [1:0] {
        MODE_XOR       = 2'd0,
        MODE_CHAIN_ENC = 2'd1,
        MODE_CHAIN_DEC = 2'd2,
        MODE_RSVD      = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_e;

endpackage

// File: rtl/stream_cipher_if.sv
// Packet, key-programming and data handshake signals of the stream cipher.
interface stream_cipher_if
    import cipher_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int KEY_DEPTH = DEF_KEY_DEPTH,
    parameter int LEN_W     = DEF_LEN_W
);
    localparam int IDX_W = $clog2(KEY_DEPTH);

    logic              KeyWe;
    logic [IDX_W-1:0]  KeyAddr;
    logic [DATA_W-1:0] KeyIn;
    logic [IDX_W:0]    NumKeys;
    logic [1:0]        Mode;
    logic [DATA_W-1:0] IV;
    logic [7:0]        ID;
    logic              Start;
    logic [LEN_W-1:0]  SizeOfData;
    logic [DATA_W-1:0] DataIn;
    logic              InValid;
    logic              InReady;
    logic [DATA_W-1:0] DataOut;
    logic              OutValid;
    logic              OutReady;
    logic [7:0]        OutID;
    logic              Busy;
    logic              Done;

    modport master (
        output KeyWe, KeyAddr, KeyIn, NumKeys, Mode, IV, ID, Start, SizeOfData,
               DataIn, InValid, OutReady,
        input  InReady, DataOut, OutValid, OutID, Busy, Done
    );

    modport slave (
        input  KeyWe, KeyAddr, KeyIn, NumKeys, Mode, IV, ID, Start, SizeOfData,
               DataIn, InValid, OutReady,
        output InReady, DataOut, OutValid, OutID, Busy, Done
    );

endinterface

// File: rtl/stream_cipher_key_table.sv
// Key register file: one write port, one combinational read port.
module key_table #(
    parameter int DATA_W    = 8,
    parameter int KEY_DEPTH = 8,
    parameter int IDX_W     = $clog2(KEY_DEPTH)
) (
    input  logic              Clk,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [IDX_W-1:0]  raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    // Contents survive reset so keys need not be reprogrammed after a reset.
    logic [DATA_W-1:0] mem_q [KEY_DEPTH];

    always_ff @(posedge Clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/stream_cipher.sv
// Packet-level XOR stream cipher with cycling key table and optional
// ciphertext chaining; one registered output stage with ready/valid.
module stream_cipher
    import cipher_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int KEY_DEPTH = DEF_KEY_DEPTH,
    parameter int LEN_W     = DEF_LEN_W
) (
    input logic            Clk,
    input logic            Reset_n,
    stream_cipher_if.slave bus
);

    localparam int IDX_W = $clog2(KEY_DEPTH);
    localparam int NK_W  = IDX_W + 1;

    state_e            state_q, state_d;
    mode_e             mode_q;
    logic [DATA_W-1:0] chain_q, out_q, key, result;
    logic [7:0]        id_q;
    logic [IDX_W-1:0]  idx_q, last_idx_q;
    logic [LEN_W-1:0]  cnt_q, size_q;
    logic              vld_q, busy_q, busy_d, done_q, done_d;
    logic              start_ok, xfer, out_pop, last_word, chained;
    logic [NK_W-1:0]   nk_eff;

    key_table #(.DATA_W(DATA_W), .KEY_DEPTH(KEY_DEPTH)) u_keys (
        .Clk     (Clk),
        .we_i    (bus.KeyWe && !busy_q),
        .waddr_i (bus.KeyAddr),
        .wdata_i (bus.KeyIn),
        .raddr_i (idx_q),
        .rdata_o (key)
    );

    // Busy is still high in the Done cycle, which blocks a Start there.
    assign start_ok  = bus.Start && (state_q == IDLE) && !busy_q;
    assign xfer      = bus.InValid && bus.InReady;
    assign out_pop   = vld_q && bus.OutReady;
    assign last_word = (cnt_q == size_q - LEN_W'(1));
    assign chained   = (mode_q == MODE_CHAIN_ENC) || (mode_q == MODE_CHAIN_DEC);
    assign result    = bus.DataIn ^ key ^ (chained ? chain_q : '0);
    assign nk_eff    = (bus.NumKeys == '0 || bus.NumKeys > NK_W'(KEY_DEPTH))
                       ? NK_W'(KEY_DEPTH) : bus.NumKeys;

    assign bus.InReady  = (state_q == RUN) && (!vld_q || bus.OutReady);
    assign bus.DataOut  = out_q;
    assign bus.OutValid = vld_q;
    assign bus.OutID    = id_q;
    assign bus.Busy     = busy_q;
    assign bus.Done     = done_q;

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_ok) begin
                    if (bus.SizeOfData != '0) state_d = RUN;
                    else                      done_d  = 1'b1;
                end
            end
            RUN:   if (xfer && last_word) state_d = FLUSH;
            FLUSH: begin
                if (out_pop) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy_d = (state_d != IDLE) || (state_q == FLUSH && out_pop);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= IDLE;
            mode_q     <= MODE_XOR;
            chain_q    <= '0;
            out_q      <= '0;
            vld_q      <= 1'b0;
            id_q       <= '0;
            idx_q      <= '0;
            last_idx_q <= '0;
            cnt_q      <= '0;
            size_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            if (start_ok) begin
                mode_q     <= (mode_e'(bus.Mode) == MODE_RSVD) ? MODE_XOR : mode_e'(bus.Mode);
                chain_q    <= bus.IV;
                id_q       <= bus.ID;
                size_q     <= bus.SizeOfData;
                last_idx_q <= IDX_W'(nk_eff - NK_W'(1));
                idx_q      <= '0;
                cnt_q      <= '0;
            end
            if (xfer) begin
                out_q <= result;
                idx_q <= (idx_q == last_idx_q) ? '0 : idx_q + IDX_W'(1);
                cnt_q <= cnt_q + LEN_W'(1);
                // Encrypt chains on ciphertext out, decrypt on ciphertext in.
                if (mode_q == MODE_CHAIN_ENC) chain_q <= result;
                if (mode_q == MODE_CHAIN_DEC) chain_q <= bus.DataIn;
            end
            if (xfer)              vld_q <= 1'b1;
            else if (bus.OutReady) vld_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_stream_cipher.sv
// Randomized bench for stream_cipher: packet-level reference model, a
// per-cycle output monitor, and directed cases with literal expectations.
module tb_stream_cipher;

    logic Clk;
    logic Reset_n;

    stream_cipher_if bus ();

    stream_cipher dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    int         tests = 0;
    int         fails = 0;
    int         done_cnt = 0;
    bit         mon_en = 0;
    logic [7:0] kmodel [8];
    logic [7:0] pkt[$];
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    logic [7:0] want[$];
    logic [7:0] exp_id = 8'h00;

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: key index is simply word number modulo the active key count.
    task automatic model_packet(input logic [1:0] mode, input logic [7:0] iv, input logic [3:0] nk);
        int n;
        logic [7:0] ch, o;
        n  = (nk == 4'd0 || nk > 4'd8) ? 8 : int'(nk);
        ch = iv;
        foreach (pkt[i]) begin
            o = pkt[i] ^ kmodel[i % n];
            if (mode == 2'd1) begin
                o  = o ^ ch;
                ch = o;
            end else if (mode == 2'd2) begin
                o  = o ^ ch;
                ch = pkt[i];
            end
            exp_q.push_back(o);
        end
    endtask

    task automatic check_exp(input string name);
        check({name, "_len"}, exp_q.size(), want.size());
        foreach (want[i]) if (i < exp_q.size()) check(name, exp_q[i], want[i]);
    endtask

    task automatic check_got(input string name);
        check({name, "_len"}, got_q.size(), want.size());
        foreach (want[i]) if (i < got_q.size()) check(name, got_q[i], want[i]);
    endtask

    task automatic write_key(input int a, input logic [7:0] v);
        bus.KeyWe   = 1'b1;
        bus.KeyAddr = 3'(a);
        bus.KeyIn   = v;
        @(posedge Clk); #1;
        bus.KeyWe   = 1'b0;
        kmodel[a]   = v;
    endtask

    task automatic start_pkt(input logic [1:0] mode, input logic [7:0] iv, input logic [7:0] id,
                             input logic [3:0] nk, input logic [7:0] size);
        bus.Mode       = mode;
        bus.IV         = iv;
        bus.ID         = id;
        bus.NumKeys    = nk;
        bus.SizeOfData = size;
        bus.Start      = 1'b1;
        exp_id         = id;
        @(posedge Clk); #1;
        bus.Start      = 1'b0;
    endtask

    task automatic drive_packet(input logic [1:0] mode, input logic [7:0] iv, input logic [7:0] id,
                                input logic [3:0] nk, input int bp, input int ivp,
                                input int stall_at, input bit poke);
        int i, cyc, stall, d0;
        bit seen;
        exp_q.delete();
        got_q.delete();
        model_packet(mode, iv, nk);
        d0 = done_cnt;
        start_pkt(mode, iv, id, nk, 8'(pkt.size()));
        i = 0; cyc = 0; stall = 3;
        while (i < pkt.size() && cyc < 1000) begin
            bus.InValid = ($urandom_range(0, 99) < ivp);
            bus.DataIn  = pkt[i];
            if (stall_at >= 0 && i >= stall_at && stall > 0) begin
                bus.OutReady = 1'b0;
                stall--;
            end else begin
                bus.OutReady = ($urandom_range(0, 99) >= bp);
            end
            bus.Start = 1'b0;
            bus.KeyWe = 1'b0;
            if (poke && cyc == 2) begin
                bus.Start      = 1'b1;
                bus.ID         = ~id;
                bus.SizeOfData = 8'd1;
                bus.KeyWe      = 1'b1;
                bus.KeyAddr    = 3'd0;
                bus.KeyIn      = ~kmodel[0];
            end
            @(negedge Clk);
            if (bus.InValid && bus.InReady) i++;
            @(posedge Clk); #1;
            cyc++;
        end
        bus.InValid = 1'b0;
        bus.Start   = 1'b0;
        bus.KeyWe   = 1'b0;
        check("input_accept_timeout", (cyc >= 1000), 0);
        if (ivp == 100 && bp == 0 && stall_at < 0) check("throughput_cycles", cyc, pkt.size());
        seen = 0; cyc = 0;
        while (!seen && cyc < 200) begin
            bus.OutReady = ($urandom_range(0, 99) >= bp);
            @(negedge Clk);
            seen = bus.Done;
            @(posedge Clk); #1;
            cyc++;
        end
        check("done_seen", seen, 1);
        bus.OutReady = 1'b1;
        repeat (3) @(posedge Clk);
        #1;
        check("done_once", done_cnt - d0, 1);
        check("all_words_out", exp_q.size(), 0);
        check("busy_after_done", bus.Busy, 0);
    endtask

    // Per-cycle monitor: every accepted output word against the model queue,
    // plus output hold and InReady rules while the output is stalled.
    initial begin
        bit         prev_stall;
        logic [7:0] prev_data, e;
        prev_stall = 0;
        prev_data  = '0;
        forever begin
            @(negedge Clk);
            if (!mon_en) begin
                prev_stall = 0;
            end else begin
                if (prev_stall) begin
                    tests++;
                    if (!(bus.OutValid === 1'b1 && bus.DataOut === prev_data)) begin
                        fails++;
                        $display("FAIL hold: OutValid=%0b DataOut=%0h, expected 1/%0h",
                                 bus.OutValid, bus.DataOut, prev_data);
                    end
                end
                if (bus.OutValid && !bus.OutReady) begin
                    tests++;
                    if (bus.InReady !== 1'b0) begin
                        fails++;
                        $display("FAIL inready_stall: got %0b, expected 0", bus.InReady);
                    end
                end
                if (bus.InReady) begin
                    tests++;
                    if (bus.Busy !== 1'b1) begin
                        fails++;
                        $display("FAIL inready_busy: Busy=%0b, expected 1", bus.Busy);
                    end
                end
                if (bus.OutValid && bus.OutReady) begin
                    got_q.push_back(bus.DataOut);
                    tests++;
                    if (exp_q.size() == 0) begin
                        fails++;
                        $display("FAIL extra_word: got %0h, expected no word", bus.DataOut);
                    end else begin
                        e = exp_q.pop_front();
                        if (bus.DataOut !== e || bus.OutID !== exp_id) begin
                            fails++;
                            $display("FAIL data_out: got %0h id %0h, expected %0h id %0h",
                                     bus.DataOut, bus.OutID, e, exp_id);
                        end
                    end
                end
                if (bus.Done) done_cnt++;
                prev_stall = bus.OutValid && !bus.OutReady;
                prev_data  = bus.DataOut;
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_dataout"}, bus.DataOut, 0);
        check({tag, "_outvalid"}, bus.OutValid, 0);
        check({tag, "_inready"}, bus.InReady, 0);
        check({tag, "_busy"}, bus.Busy, 0);
        check({tag, "_done"}, bus.Done, 0);
        check({tag, "_outid"}, bus.OutID, 0);
    endtask

    initial begin
        int i, cyc, d0;
        bus.KeyWe = 0; bus.KeyAddr = '0; bus.KeyIn = '0; bus.NumKeys = '0;
        bus.Mode = '0; bus.IV = '0; bus.ID = '0; bus.Start = 0; bus.SizeOfData = '0;
        bus.DataIn = '0; bus.InValid = 0; bus.OutReady = 1;
        Reset_n = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        check_reset_outputs("reset");
        Reset_n = 1'b1;
        @(posedge Clk); #1;
        mon_en = 1;

        write_key(0, 8'h11); write_key(1, 8'h22); write_key(2, 8'h33); write_key(3, 8'h44);
        for (int k = 4; k < 8; k++) write_key(k, 8'($urandom));

        // Plain XOR, full throughput
        pkt = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        want = '{8'h11, 8'h23, 8'h31, 8'h47, 8'h15, 8'h27};
        exp_q.delete();
        model_packet(2'd0, 8'h00, 4'd4);
        check_exp("model_xor");
        drive_packet(2'd0, 8'h00, 8'h5A, 4'd4, 0, 100, -1, 0);
        check_got("xor_out");
        check("xor_outid", bus.OutID, 8'h5A);

        // Chain encrypt then decrypt with one key
        write_key(0, 8'h0F);
        pkt = '{8'h10, 8'h20};
        want = '{8'hBA, 8'h95};
        exp_q.delete();
        model_packet(2'd1, 8'hA5, 4'd1);
        check_exp("model_chain_enc");
        drive_packet(2'd1, 8'hA5, 8'h21, 4'd1, 0, 100, -1, 0);
        check_got("chain_enc");
        pkt = '{8'hBA, 8'h95};
        want = '{8'h10, 8'h20};
        exp_q.delete();
        model_packet(2'd2, 8'hA5, 4'd1);
        check_exp("model_chain_dec");
        drive_packet(2'd2, 8'hA5, 8'h22, 4'd1, 0, 100, -1, 0);
        check_got("chain_dec");
        write_key(0, 8'h11);

        // Three-cycle output stall mid-packet
        pkt.delete();
        for (int k = 0; k < 8; k++) pkt.push_back(8'($urandom));
        drive_packet(2'd1, 8'h3C, 8'h33, 4'd4, 0, 100, 3, 0);
        check("stall_count", got_q.size(), 8);

        // Zero-length packet
        d0 = done_cnt;
        start_pkt(2'd0, 8'h00, 8'h77, 4'd4, 8'd0);
        check("zl_done", bus.Done, 1);
        check("zl_busy", bus.Busy, 0);
        check("zl_outvalid", bus.OutValid, 0);
        @(posedge Clk); #1;
        check("zl_done_drop", bus.Done, 0);
        check("zl_busy2", bus.Busy, 0);
        check("zl_outid", bus.OutID, 8'h77);
        check("zl_done_cnt", done_cnt - d0, 1);

        // Key write and Start while busy are ignored
        pkt.delete();
        for (int k = 0; k < 6; k++) pkt.push_back(8'($urandom));
        drive_packet(2'd0, 8'h00, 8'h44, 4'd4, 0, 100, -1, 1);
        pkt = '{8'h00, 8'h00, 8'h00, 8'h00};
        want = '{8'h11, 8'h22, 8'h33, 8'h44};
        drive_packet(2'd0, 8'h00, 8'h45, 4'd4, 0, 100, -1, 0);
        check_got("key_protect");

        // NumKeys 0 and out-of-range both cycle the whole table
        pkt.delete();
        for (int k = 0; k < 20; k++) pkt.push_back(8'h00);
        drive_packet(2'd0, 8'h00, 8'h50, 4'd0, 20, 100, -1, 0);
        check("nk0_idx3", got_q[3], 8'h44);
        check("nk0_wrap", got_q[8], 8'h11);
        check("nk0_wrap2", got_q[11], 8'h44);
        drive_packet(2'd0, 8'h00, 8'h51, 4'd12, 0, 100, -1, 0);
        check("nk12_wrap", got_q[9], 8'h22);

        // Randomized packets
        for (int n = 0; n < 14; n++) begin
            pkt.delete();
            for (int k = 0; k < $urandom_range(1, 12); k++) pkt.push_back(8'($urandom));
            drive_packet(2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom),
                         4'($urandom_range(0, 15)), $urandom_range(0, 50),
                         $urandom_range(50, 100), -1, 0);
        end

        // Asynchronous reset two words into a five-word packet
        pkt.delete();
        for (int k = 0; k < 5; k++) pkt.push_back(8'($urandom));
        exp_q.delete(); got_q.delete();
        model_packet(2'd0, 8'h00, 4'd4);
        bus.OutReady = 1'b1;
        start_pkt(2'd0, 8'h00, 8'h66, 4'd4, 8'd5);
        i = 0; cyc = 0;
        while (i < 2 && cyc < 50) begin
            bus.InValid = 1'b1;
            bus.DataIn  = pkt[i];
            @(negedge Clk);
            if (bus.InValid && bus.InReady) i++;
            @(posedge Clk); #1;
            cyc++;
        end
        bus.InValid = 1'b0;
        check("rst_pre_busy", bus.Busy, 1);
        mon_en = 0;
        #1 Reset_n = 1'b0;
        #1;
        check_reset_outputs("rst_mid");
        repeat (2) begin
            @(negedge Clk);
            check("rst_hold_done", bus.Done, 0);
        end
        @(posedge Clk); #1;
        Reset_n = 1'b1;
        exp_q.delete(); got_q.delete();
        mon_en = 1;
        @(posedge Clk); #1;
        pkt.delete();
        for (int k = 0; k < 5; k++) pkt.push_back(8'($urandom));
        drive_packet(2'd0, 8'h00, 8'h67, 4'd4, 0, 100, -1, 0);
        if (got_q.size() > 1) begin
            check("rst_after_w0", got_q[0], pkt[0] ^ 8'h11);
            check("rst_after_w1", got_q[1], pkt[1] ^ 8'h22);
        end else begin
            check("rst_after_len", got_q.size(), 5);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
